// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg : opcode map and FSM state encoding shared by alu_mc.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_AND   = 4'd2;
    localparam logic [OP_W-1:0] OP_OR    = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL   = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL   = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA   = 4'd7;
    localparam logic [OP_W-1:0] OP_SLT   = 4'd8;
    localparam logic [OP_W-1:0] OP_SLTU  = 4'd9;
    localparam logic [OP_W-1:0] OP_MUL   = 4'd10;
    localparam logic [OP_W-1:0] OP_MULHU = 4'd11;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd12;
    localparam logic [OP_W-1:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mc_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_mc_muldiv : one-bit-per-cycle shift-add multiplier / restoring divider|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_mc_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             hi_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             done
);

    localparam int              SH_W     = $clog2(WIDTH);
    localparam logic [SH_W-1:0] CNT_INIT = SH_W'(WIDTH - 1);

    // acc holds {partial product hi, multiplier} or {remainder, quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d, w_step;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [SH_W-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               mode_q, mode_d;
    logic               hi_sel_q, hi_sel_d;
    logic [WIDTH:0]     w_sum, w_trial;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;

    always_comb begin
        w_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        w_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        w_ge    = (w_trial >= {1'b0, b_q});
        w_diff  = w_trial[WIDTH-1:0] - b_q;
        if (mode_q) begin
            w_step = {(w_ge ? w_diff : w_trial[WIDTH-1:0]), acc_q[WIDTH-2:0], w_ge};
        end else begin
            w_step = {w_sum, acc_q[WIDTH-1:1]};
        end
    end

    assign done = busy_q && (cnt_q == '0);
    assign res  = hi_sel_q ? w_step[2*WIDTH-1:WIDTH] : w_step[WIDTH-1:0];

    always_comb begin
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        mode_d   = mode_q;
        hi_sel_d = hi_sel_q;
        if (start) begin
            acc_d    = {{WIDTH{1'b0}}, a};
            b_d      = b;
            cnt_d    = CNT_INIT;
            busy_d   = 1'b1;
            mode_d   = mode;
            hi_sel_d = hi_sel;
        end else if (busy_q) begin
            acc_d = w_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            mode_q   <= 1'b0;
            hi_sel_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            mode_q   <= mode_d;
            hi_sel_q <= hi_sel_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_mc : multi-cycle ALU with valid/ready handshakes and status flags.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_zero,
    output logic             busy
);
    import alu_pkg::*;

    localparam int SH_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             div_zero_q, div_zero_d;

    logic             w_accept, w_iter, w_b_zero, w_md_done;
    logic [WIDTH-1:0] w_md_res, w_res;
    logic             w_carry, w_ovf, w_dz;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [SH_W-1:0]  w_sh;

    assign w_b_zero  = (b == '0);
    assign w_iter    = (op == OP_MUL) || (op == OP_MULHU) ||
                       (((op == OP_DIVU) || (op == OP_REMU)) && !w_b_zero);
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign div_zero  = div_zero_q;

    alu_mc_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_accept && w_iter),
        .mode   ((op == OP_DIVU) || (op == OP_REMU)),
        .hi_sel ((op == OP_MULHU) || (op == OP_REMU)),
        .a      (a),
        .b      (b),
        .res    (w_md_res),
        .done   (w_md_done)
    );

    always_comb begin
        w_sum   = {1'b0, a} + {1'b0, b};
        w_diff  = {1'b0, a} - {1'b0, b};
        w_sh    = b[SH_W-1:0];
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_dz    = 1'b0;
        case (op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_SLL:  w_res = a << w_sh;
            OP_SRL:  w_res = a >> w_sh;
            OP_SRA:  w_res = $signed(a) >>> w_sh;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
            // Only reached with b == 0; nonzero divisors take the iterative path
            OP_DIVU: begin
                w_res = '1;
                w_dz  = 1'b1;
            end
            OP_REMU: begin
                w_res = a;
                w_dz  = 1'b1;
            end
            default: w_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        div_zero_d = div_zero_q;
        case (state_q)
            ST_IDLE: if (w_accept) state_d = w_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_md_done) state_d = ST_DONE;
            ST_DONE: begin
                if (w_accept) begin
                    state_d = w_iter ? ST_BUSY : ST_DONE;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_accept && !w_iter) begin
            result_d   = w_res;
            zero_d     = (w_res == '0);
            carry_d    = w_carry;
            overflow_d = w_ovf;
            div_zero_d = w_dz;
        end else if ((state_q == ST_BUSY) && w_md_done) begin
            result_d   = w_md_res;
            zero_d     = (w_md_res == '0);
            carry_d    = 1'b0;
            overflow_d = 1'b0;
            div_zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            div_zero_q <= div_zero_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_mc : directed self-checking bench with a behavioural ALU model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_mc;

    localparam int WIDTH = 32;
    localparam logic [3:0] C_ADD = 4'd0,  C_SUB = 4'd1,  C_AND = 4'd2,  C_OR = 4'd3;
    localparam logic [3:0] C_XOR = 4'd4,  C_SLL = 4'd5,  C_SRL = 4'd6,  C_SRA = 4'd7;
    localparam logic [3:0] C_SLT = 4'd8,  C_SLTU = 4'd9, C_MUL = 4'd10, C_MULHU = 4'd11;
    localparam logic [3:0] C_DIVU = 4'd12, C_REMU = 4'd13;
    localparam longint C_SMAX = 64'sd2147483647;
    localparam longint C_SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  op;
    logic        zero, carry, overflow, div_zero, busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    alu_mc #(.WIDTH(WIDTH), .OP_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        dz;
    } exp_t;

    function automatic exp_t calc(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t            e;
        longint          sx, sy, s;
        longint unsigned ux, uy, p;
        logic [4:0]      sh;
        e  = '0;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        sh = y[4:0];
        case (o)
            C_ADD: begin
                s = sx + sy;
                e.res = x + y;
                e.c = (ux + uy) > 64'hFFFF_FFFF;
                e.v = (s > C_SMAX) || (s < C_SMIN);
            end
            C_SUB: begin
                s = sx - sy;
                e.res = x - y;
                e.c = (x < y);
                e.v = (s > C_SMAX) || (s < C_SMIN);
            end
            C_AND:  e.res = x & y;
            C_OR:   e.res = x | y;
            C_XOR:  e.res = x ^ y;
            C_SLL:  e.res = x << sh;
            C_SRL:  e.res = x >> sh;
            C_SRA:  e.res = 32'(sx >>> sh);
            C_SLT:  e.res = (sx < sy) ? 32'd1 : 32'd0;
            C_SLTU: e.res = (x < y) ? 32'd1 : 32'd0;
            C_MUL:   begin p = ux * uy; e.res = p[31:0];  end
            C_MULHU: begin p = ux * uy; e.res = p[63:32]; end
            C_DIVU: begin
                if (y == 0) begin e.res = 32'hFFFF_FFFF; e.dz = 1'b1; end
                else e.res = x / y;
            end
            C_REMU: begin
                if (y == 0) begin e.res = x; e.dz = 1'b1; end
                else e.res = x % y;
            end
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    function automatic bit is_iter(input logic [3:0] o, input logic [31:0] y);
        return (o == C_MUL) || (o == C_MULHU) || (((o == C_DIVU) || (o == C_REMU)) && (y != 0));
    endfunction

    // Model: a result is either showing, pending for m_left cycles, or absent
    exp_t m_cur;
    bit   m_valid;
    int   m_left;
    logic m_rdy, m_acc;

    assign m_rdy = ((m_left == 0) && !m_valid) || (m_valid && out_ready);
    assign m_acc = in_valid && m_rdy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_left  <= 0;
        end else if (m_acc) begin
            m_cur <= calc(op, a, b);
            if (is_iter(op, b)) begin
                m_left  <= WIDTH;
                m_valid <= 1'b0;
            end else begin
                m_left  <= 0;
                m_valid <= 1'b1;
            end
        end else if (m_left > 0) begin
            m_left  <= m_left - 1;
            m_valid <= (m_left == 1);
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(m_rdy));
            chk("busy", 64'(busy), 64'(m_left > 0));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("result", 64'(result), 64'(m_cur.res));
                chk("zero", 64'(zero), 64'(m_cur.z));
                chk("carry", 64'(carry), 64'(m_cur.c));
                chk("overflow", 64'(overflow), 64'(m_cur.v));
                chk("div_zero", 64'(div_zero), 64'(m_cur.dz));
            end
        end
    end

    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic took;
        took = 1'b0;
        op = o; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 100 && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        if (!took) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: op %0d not accepted", o);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n_lat, c_start;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        send(C_ADD, 32'h7FFF_FFFF, 32'd1);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_res", 64'(result), 64'h8000_0000);
        chk("add_ovf", 64'(overflow), 64'd1);
        chk("add_carry", 64'(carry), 64'd0);
        chk("add_zero", 64'(zero), 64'd0);
        send(C_SUB, 32'd5, 32'd5);
        chk("sub_res", 64'(result), 64'd0);
        chk("sub_zero", 64'(zero), 64'd1);
        chk("sub_carry", 64'(carry), 64'd0);
        send(C_ADD, 32'hFFFF_FFFF, 32'd1);
        chk("add_wrap_carry", 64'(carry), 64'd1);
        send(C_SUB, 32'd3, 32'd5);
        chk("sub_borrow_res", 64'(result), 64'hFFFF_FFFE);
        chk("sub_borrow", 64'(carry), 64'd1);
        send(C_SUB, 32'h8000_0000, 32'd1);
        chk("sub_ovf", 64'(overflow), 64'd1);
        send(C_SRL, 32'h8000_0000, 32'd31);
        chk("srl_res", 64'(result), 64'd1);

        c_start = cyc;
        send(C_AND, 32'hF0F0_1234, 32'hFF00_FF00);
        chk("and_res", 64'(result), 64'hF000_1200);
        send(C_OR, 32'h0F0F_0000, 32'h0000_00F0);
        chk("or_res", 64'(result), 64'h0F0F_00F0);
        send(C_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F);
        chk("xor_res", 64'(result), 64'hF0F0_0F0F);
        send(C_SLL, 32'd1, 32'd35);
        chk("sll_res", 64'(result), 64'h8);
        send(C_SRA, 32'h8000_0000, 32'd4);
        chk("sra_res", 64'(result), 64'hF800_0000);
        send(C_SLT, 32'hFFFF_FFFF, 32'd1);
        chk("slt_res", 64'(result), 64'd1);
        send(C_SLTU, 32'hFFFF_FFFF, 32'd1);
        chk("sltu_res", 64'(result), 64'd0);
        send(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("op15_res", 64'(result), 64'd0);
        chk("op15_zero", 64'(zero), 64'd1);
        chk("b2b_cycles", 64'(cyc - c_start), 64'd8);
        in_valid = 1'b0;
        tick();

        send(C_MUL, 32'h0001_0000, 32'h0001_0000);
        in_valid = 1'b0;
        chk("mul_busy", 64'(busy), 64'd1);
        chk("mul_in_ready", 64'(in_ready), 64'd0);
        wait_valid(n_lat);
        chk("mul_latency", 64'(n_lat), 64'd33);
        chk("mul_res", 64'(result), 64'd0);
        chk("mul_zero", 64'(zero), 64'd1);
        send(C_MULHU, 32'h0001_0000, 32'h0001_0000);
        in_valid = 1'b0;
        wait_valid(n_lat);
        chk("mulhu_res", 64'(result), 64'd1);
        send(C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        wait_valid(n_lat);
        chk("mulhu_max", 64'(result), 64'hFFFF_FFFE);

        send(C_DIVU, 32'd100, 32'd7);
        in_valid = 1'b0;
        wait_valid(n_lat);
        chk("divu_latency", 64'(n_lat), 64'd33);
        chk("divu_res", 64'(result), 64'd14);
        send(C_REMU, 32'd100, 32'd7);
        in_valid = 1'b0;
        wait_valid(n_lat);
        chk("remu_res", 64'(result), 64'd2);
        send(C_DIVU, 32'd9, 32'd0);
        chk("div0_valid", 64'(out_valid), 64'd1);
        chk("div0_res", 64'(result), 64'hFFFF_FFFF);
        chk("div0_flag", 64'(div_zero), 64'd1);
        send(C_REMU, 32'd9, 32'd0);
        chk("rem0_res", 64'(result), 64'd9);
        chk("rem0_flag", 64'(div_zero), 64'd1);
        send(C_DIVU, 32'hFFFF_FFFF, 32'd1);
        in_valid = 1'b0;
        wait_valid(n_lat);
        chk("divu_by1", 64'(result), 64'hFFFF_FFFF);
        tick();

        out_ready = 1'b0;
        send(C_ADD, 32'd10, 32'd20);
        chk("bp_first", 64'(result), 64'd30);
        op = C_SUB; a = 32'd50; b = 32'd8; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_res", 64'(result), 64'd30);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        send(C_SUB, 32'd50, 32'd8);
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_res", 64'(result), 64'd42);
        in_valid = 1'b0;

        send(C_DIVU, 32'd1000, 32'd3);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        send(C_ADD, 32'd2, 32'd3);
        chk("post_rst_add", 64'(result), 64'd5);
        in_valid = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
